// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer between dispatch and retirement.
// Allocates up to DISP_WIDTH entries per cycle, marks entries complete from
// NUM_FUS writeback ports, retires up to RETIRE_WIDTH entries per cycle in
// program order, and raises a one-cycle flush when a faulting entry reaches
// the retire window.
// Optional build macro ROB_PERF_CNT_EN adds perf_retired/perf_flushes counters.
//
// Allocation handshake: a lane is accepted on a rising edge when its
// alloc_valid bit is set, alloc_ready=1 and no flush is signalled in that
// cycle; alloc_valid while alloc_ready=0 is ignored and must be re-presented.
module reorder_buffer #(
    parameter int NUM_ROB_ENTS = 64,
    parameter int DISP_WIDTH   = 2,
    parameter int RETIRE_WIDTH = 4,
    parameter int NUM_FUS      = 4,
    parameter int NUM_PREGS    = 128,
    parameter int NUM_AREGS    = 32,
    localparam int IW = $clog2(NUM_ROB_ENTS),
    localparam int PW = $clog2(NUM_PREGS),
    localparam int AW = $clog2(NUM_AREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DISP_WIDTH-1:0]      alloc_valid,
    input  logic [DISP_WIDTH*AW-1:0]   alloc_dst_areg,
    input  logic [DISP_WIDTH*PW-1:0]   alloc_dst_preg,
    input  logic [DISP_WIDTH*32-1:0]   alloc_pc,
    output logic                       alloc_ready,
    output logic [DISP_WIDTH*IW-1:0]   alloc_rob_index,
    input  logic [NUM_FUS-1:0]         cmpl_valid,
    input  logic [NUM_FUS*IW-1:0]      cmpl_rob_index,
    input  logic [NUM_FUS-1:0]         cmpl_exception,
    input  logic [NUM_FUS-1:0]         cmpl_br_mispred,
    output logic [RETIRE_WIDTH-1:0]    retire_valid,
    output logic [RETIRE_WIDTH*AW-1:0] retire_dst_areg,
    output logic [RETIRE_WIDTH*PW-1:0] retire_dst_preg,
    output logic [RETIRE_WIDTH*32-1:0] retire_pc,
    output logic                       flush_valid,
    output logic [31:0]                flush_pc,
    output logic                       flush_is_exc,
`ifdef ROB_PERF_CNT_EN
    output logic [31:0]                perf_retired,
    output logic [31:0]                perf_flushes,
`endif
    output logic                       rob_empty
);

    typedef struct packed {
        logic [AW-1:0] dst_areg;
        logic [PW-1:0] dst_preg;
        logic [31:0]   pc;
    } rob_entry_t;

    localparam logic [IW:0] CNT_ONE  = (IW+1)'(1);
    localparam logic [IW:0] CNT_FULL = (IW+1)'(NUM_ROB_ENTS - DISP_WIDTH);

    logic [NUM_ROB_ENTS-1:0] valid_q, valid_d;
    logic [NUM_ROB_ENTS-1:0] done_q, done_d;
    logic [NUM_ROB_ENTS-1:0] exc_q, exc_d;
    logic [NUM_ROB_ENTS-1:0] mis_q, mis_d;
    rob_entry_t              payload_q [NUM_ROB_ENTS];
    rob_entry_t              payload_d [NUM_ROB_ENTS];
    logic [IW-1:0]           head_q, head_d;
    logic [IW-1:0]           tail_q, tail_d;
    logic [IW:0]             count_q, count_d;
    logic [IW:0]             n_ret;
    logic [IW:0]             n_alloc;

    // Dispatch-side status: derived only from registered occupancy.
    always_comb begin
        alloc_ready = (count_q <= CNT_FULL);
        rob_empty   = (count_q == '0);
        for (int i = 0; i < DISP_WIDTH; i++) begin
            alloc_rob_index[i*IW +: IW] = tail_q + IW'(i);
        end
    end

    // Retire window scan from head: stop at the first not-done entry,
    // at an exception (which does not retire), or after a mispredict (which does).
    always_comb begin
        logic [IW-1:0] idx;
        logic          stop;
        idx             = '0;
        stop            = 1'b0;
        n_ret           = '0;
        retire_valid    = '0;
        retire_dst_areg = '0;
        retire_dst_preg = '0;
        retire_pc       = '0;
        flush_valid     = 1'b0;
        flush_pc        = '0;
        flush_is_exc    = 1'b0;
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
            idx = head_q + IW'(k);
            if (!stop) begin
                if (valid_q[idx] && done_q[idx]) begin
                    if (exc_q[idx]) begin
                        flush_valid  = 1'b1;
                        flush_pc     = payload_q[idx].pc;
                        flush_is_exc = 1'b1;
                        stop         = 1'b1;
                    end else begin
                        retire_valid[k]            = 1'b1;
                        retire_dst_areg[k*AW +: AW] = payload_q[idx].dst_areg;
                        retire_dst_preg[k*PW +: PW] = payload_q[idx].dst_preg;
                        retire_pc[k*32 +: 32]       = payload_q[idx].pc;
                        n_ret                       = n_ret + CNT_ONE;
                        if (mis_q[idx]) begin
                            flush_valid  = 1'b1;
                            flush_pc     = payload_q[idx].pc;
                            flush_is_exc = 1'b0;
                            stop         = 1'b1;
                        end
                    end
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    // Next state: completions, then retire clears, then allocation writes.
    // A flush discards everything including same-cycle allocs and completions.
    always_comb begin
        logic [IW-1:0] cidx;
        logic [IW-1:0] aidx;
        cidx      = '0;
        aidx      = '0;
        valid_d   = valid_q;
        done_d    = done_q;
        exc_d     = exc_q;
        mis_d     = mis_q;
        payload_d = payload_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        n_alloc   = '0;
        if (flush_valid) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                cidx = cmpl_rob_index[f*IW +: IW];
                if (cmpl_valid[f] && valid_q[cidx]) begin
                    done_d[cidx] = 1'b1;
                    exc_d[cidx]  = exc_d[cidx] | cmpl_exception[f];
                    mis_d[cidx]  = mis_d[cidx] | cmpl_br_mispred[f];
                end
            end
            for (int k = 0; k < RETIRE_WIDTH; k++) begin
                if (retire_valid[k]) begin
                    valid_d[head_q + IW'(k)] = 1'b0;
                end
            end
            if (alloc_ready) begin
                for (int i = 0; i < DISP_WIDTH; i++) begin
                    if (alloc_valid[i]) begin
                        aidx                     = tail_q + IW'(i);
                        valid_d[aidx]            = 1'b1;
                        done_d[aidx]             = 1'b0;
                        exc_d[aidx]              = 1'b0;
                        mis_d[aidx]              = 1'b0;
                        payload_d[aidx].dst_areg = alloc_dst_areg[i*AW +: AW];
                        payload_d[aidx].dst_preg = alloc_dst_preg[i*PW +: PW];
                        payload_d[aidx].pc       = alloc_pc[i*32 +: 32];
                        n_alloc                  = n_alloc + CNT_ONE;
                    end
                end
            end
            head_d  = head_q + n_ret[IW-1:0];
            tail_d  = tail_q + n_alloc[IW-1:0];
            count_d = count_q + n_alloc - n_ret;
        end
    end

    // State registers; reset overrides flush, allocation and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
            mis_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
            mis_q   <= mis_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage; contents are qualified by valid so it needs no reset.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    // Free-running event counters; wrap naturally at 2^32.
    always_comb begin
        perf_retired_d = perf_retired_q + 32'(n_ret);
        perf_flushes_d = perf_flushes_q + {31'd0, flush_valid};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer (default parameters).
module tb_reorder_buffer;

    localparam int DW = 2;
    localparam int RW = 4;
    localparam int NF = 4;
    localparam int IW = 6;
    localparam int PW = 7;
    localparam int AW = 5;

    logic              clk;
    logic              rst;
    logic [DW-1:0]     alloc_valid;
    logic [DW*AW-1:0]  alloc_dst_areg;
    logic [DW*PW-1:0]  alloc_dst_preg;
    logic [DW*32-1:0]  alloc_pc;
    logic              alloc_ready;
    logic [DW*IW-1:0]  alloc_rob_index;
    logic [NF-1:0]     cmpl_valid;
    logic [NF*IW-1:0]  cmpl_rob_index;
    logic [NF-1:0]     cmpl_exception;
    logic [NF-1:0]     cmpl_br_mispred;
    logic [RW-1:0]     retire_valid;
    logic [RW*AW-1:0]  retire_dst_areg;
    logic [RW*PW-1:0]  retire_dst_preg;
    logic [RW*32-1:0]  retire_pc;
    logic              flush_valid;
    logic [31:0]       flush_pc;
    logic              flush_is_exc;
    logic              rob_empty;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]       perf_retired;
    logic [31:0]       perf_flushes;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    reorder_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_dst_areg  (alloc_dst_areg),
        .alloc_dst_preg  (alloc_dst_preg),
        .alloc_pc        (alloc_pc),
        .alloc_ready     (alloc_ready),
        .alloc_rob_index (alloc_rob_index),
        .cmpl_valid      (cmpl_valid),
        .cmpl_rob_index  (cmpl_rob_index),
        .cmpl_exception  (cmpl_exception),
        .cmpl_br_mispred (cmpl_br_mispred),
        .retire_valid    (retire_valid),
        .retire_dst_areg (retire_dst_areg),
        .retire_dst_preg (retire_dst_preg),
        .retire_pc       (retire_pc),
        .flush_valid     (flush_valid),
        .flush_pc        (flush_pc),
        .flush_is_exc    (flush_is_exc),
`ifdef ROB_PERF_CNT_EN
        .perf_retired    (perf_retired),
        .perf_flushes    (perf_flushes),
`endif
        .rob_empty       (rob_empty)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid     = '0;
        alloc_dst_areg  = '0;
        alloc_dst_preg  = '0;
        alloc_pc        = '0;
        cmpl_valid      = '0;
        cmpl_rob_index  = '0;
        cmpl_exception  = '0;
        cmpl_br_mispred = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // areg = pc[6:2], preg = pc[8:2] for each lane
    task automatic drive_alloc(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        alloc_valid    = v;
        alloc_pc       = {pc1, pc0};
        alloc_dst_areg = {pc1[6:2], pc0[6:2]};
        alloc_dst_preg = {pc1[8:2], pc0[8:2]};
    endtask

    task automatic drive_cmpl(input int f, input logic [IW-1:0] idx, input logic exc, input logic mis);
        cmpl_valid[f]              = 1'b1;
        cmpl_rob_index[f*IW +: IW] = idx;
        cmpl_exception[f]          = exc;
        cmpl_br_mispred[f]         = mis;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_alloc(2'b11, 32'h50, 32'h54);
        drive_cmpl(0, 6'd0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        rst = 1'b0;
        n_tests++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %0h exp 1", alloc_ready); end
        n_tests++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rob_empty got %0h exp 1", rob_empty); end
        n_tests++; if (retire_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_retire_valid got %0h exp 0", retire_valid); end
        n_tests++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flush_valid got %0h exp 0", flush_valid); end
        n_tests++; if (flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc got %0h exp 0", flush_pc); end
        n_tests++; if (flush_is_exc !== 1'b0) begin n_fail++; $display("FAIL reset_flush_is_exc got %0h exp 0", flush_is_exc); end
        n_tests++; if (alloc_rob_index[IW-1:0] !== 6'd0) begin n_fail++; $display("FAIL reset_alloc_index got %0h exp 0", alloc_rob_index[IW-1:0]); end
    endtask

    task automatic test_basic();
        do_reset();
        drive_alloc(2'b11, 32'h100, 32'h104);
        n_tests++; if (alloc_rob_index !== {6'd1, 6'd0}) begin n_fail++; $display("FAIL basic_alloc_index got %0h exp 40", alloc_rob_index); end
        tick();
        clear_inputs();
        n_tests++; if (rob_empty !== 1'b0) begin n_fail++; $display("FAIL basic_not_empty got %0h exp 0", rob_empty); end
        n_tests++; if (alloc_rob_index[IW-1:0] !== 6'd2) begin n_fail++; $display("FAIL basic_tail got %0h exp 2", alloc_rob_index[IW-1:0]); end
        n_tests++; if (retire_valid !== 4'b0000) begin n_fail++; $display("FAIL basic_no_retire got %0h exp 0", retire_valid); end
        drive_cmpl(0, 6'd0, 1'b0, 1'b0);
        drive_cmpl(1, 6'd1, 1'b0, 1'b0);
        tick();
        clear_inputs();
        n_tests++; if (retire_valid !== 4'b0011) begin n_fail++; $display("FAIL basic_retire_valid got %0h exp 3", retire_valid); end
        n_tests++; if (retire_pc[31:0] !== 32'h100) begin n_fail++; $display("FAIL basic_retire_pc0 got %0h exp 100", retire_pc[31:0]); end
        n_tests++; if (retire_pc[63:32] !== 32'h104) begin n_fail++; $display("FAIL basic_retire_pc1 got %0h exp 104", retire_pc[63:32]); end
        n_tests++; if (retire_dst_areg[9:5] !== 5'd1) begin n_fail++; $display("FAIL basic_retire_areg1 got %0h exp 1", retire_dst_areg[9:5]); end
        n_tests++; if (retire_dst_preg[6:0] !== 7'h40) begin n_fail++; $display("FAIL basic_retire_preg0 got %0h exp 40", retire_dst_preg[6:0]); end
        n_tests++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_flush got %0h exp 0", flush_valid); end
        tick();
        n_tests++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after got %0h exp 1", rob_empty); end
        n_tests++; if (retire_valid !== 4'b0000) begin n_fail++; $display("FAIL basic_retire_after got %0h exp 0", retire_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 32; c++) begin
            drive_alloc(2'b11, 32'h2000 + 32'(8*c), 32'h2004 + 32'(8*c));
            n_tests++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_cycle%0d got %0h exp 1", c, alloc_ready); end
            tick();
        end
        n_tests++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got %0h exp 0", alloc_ready); end
        for (int c = 0; c < 3; c++) begin
            drive_alloc(2'b11, 32'h3000, 32'h3004);
            tick();
        end
        clear_inputs();
        n_tests++; if (alloc_rob_index[IW-1:0] !== 6'd0) begin n_fail++; $display("FAIL fill_tail_held got %0h exp 0", alloc_rob_index[IW-1:0]); end
        n_tests++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_still_full got %0h exp 0", alloc_ready); end
        n_tests++; if (rob_empty !== 1'b0) begin n_fail++; $display("FAIL fill_not_empty got %0h exp 0", rob_empty); end
        drive_cmpl(0, 6'd0, 1'b0, 1'b0);
        drive_cmpl(1, 6'd1, 1'b0, 1'b0);
        tick();
        clear_inputs();
        n_tests++; if (retire_valid !== 4'b0011) begin n_fail++; $display("FAIL fill_retire got %0h exp 3", retire_valid); end
        n_tests++; if (retire_pc[31:0] !== 32'h2000) begin n_fail++; $display("FAIL fill_retire_pc got %0h exp 2000", retire_pc[31:0]); end
        tick();
        n_tests++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_again got %0h exp 1", alloc_ready); end
    endtask

    task automatic test_ooo();
        do_reset();
        drive_alloc(2'b11, 32'h200, 32'h204);
        tick();
        drive_alloc(2'b11, 32'h208, 32'h20c);
        tick();
        clear_inputs();
        drive_cmpl(0, 6'd3, 1'b0, 1'b0);
        tick();
        clear_inputs();
        n_tests++; if (retire_valid !== 4'b0000) begin n_fail++; $display("FAIL ooo_wait1 got %0h exp 0", retire_valid); end
        drive_cmpl(1, 6'd2, 1'b0, 1'b0);
        drive_cmpl(2, 6'd1, 1'b0, 1'b0);
        tick();
        clear_inputs();
        n_tests++; if (retire_valid !== 4'b0000) begin n_fail++; $display("FAIL ooo_wait2 got %0h exp 0", retire_valid); end
        drive_cmpl(3, 6'd0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        n_tests++; if (retire_valid !== 4'b1111) begin n_fail++; $display("FAIL ooo_retire4 got %0h exp f", retire_valid); end
        n_tests++; if (retire_pc[127:96] !== 32'h20c) begin n_fail++; $display("FAIL ooo_pc3 got %0h exp 20c", retire_pc[127:96]); end
        n_tests++; if (retire_pc[95:64] !== 32'h208) begin n_fail++; $display("FAIL ooo_pc2 got %0h exp 208", retire_pc[95:64]); end
        tick();
        n_tests++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL ooo_empty got %0h exp 1", rob_empty); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive_alloc(2'b11, 32'h300, 32'h304);
        tick();
        drive_alloc(2'b11, 32'h308, 32'h30c);
        tick();
        clear_inputs();
        drive_cmpl(0, 6'd0, 1'b0, 1'b0);
        drive_cmpl(1, 6'd1, 1'b0, 1'b1);
        drive_cmpl(2, 6'd2, 1'b0, 1'b0);
        drive_cmpl(3, 6'd3, 1'b0, 1'b0);
        tick();
        clear_inputs();
        n_tests++; if (retire_valid !== 4'b0011) begin n_fail++; $display("FAIL mis_retire got %0h exp 3", retire_valid); end
        n_tests++; if (flush_valid !== 1'b1) begin n_fail++; $display("FAIL mis_flush got %0h exp 1", flush_valid); end
        n_tests++; if (flush_pc !== 32'h304) begin n_fail++; $display("FAIL mis_flush_pc got %0h exp 304", flush_pc); end
        n_tests++; if (flush_is_exc !== 1'b0) begin n_fail++; $display("FAIL mis_is_exc got %0h exp 0", flush_is_exc); end
        tick();
        n_tests++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL mis_empty got %0h exp 1", rob_empty); end
        n_tests++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush_pulse got %0h exp 0", flush_valid); end
        n_tests++; if (alloc_rob_index[IW-1:0] !== 6'd0) begin n_fail++; $display("FAIL mis_tail_reset got %0h exp 0", alloc_rob_index[IW-1:0]); end
    endtask

    task automatic test_exception();
        do_reset();
        drive_alloc(2'b11, 32'h400, 32'h404);
        tick();
        clear_inputs();
        drive_cmpl(0, 6'd0, 1'b1, 1'b0);
        drive_cmpl(1, 6'd1, 1'b0, 1'b0);
        tick();
        clear_inputs();
        drive_alloc(2'b11, 32'h500, 32'h504);
        n_tests++; if (retire_valid !== 4'b0000) begin n_fail++; $display("FAIL exc_retire got %0h exp 0", retire_valid); end
        n_tests++; if (flush_valid !== 1'b1) begin n_fail++; $display("FAIL exc_flush got %0h exp 1", flush_valid); end
        n_tests++; if (flush_is_exc !== 1'b1) begin n_fail++; $display("FAIL exc_is_exc got %0h exp 1", flush_is_exc); end
        n_tests++; if (flush_pc !== 32'h400) begin n_fail++; $display("FAIL exc_flush_pc got %0h exp 400", flush_pc); end
        tick();
        clear_inputs();
        n_tests++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL exc_alloc_dropped got %0h exp 1", rob_empty); end
        n_tests++; if (alloc_rob_index[IW-1:0] !== 6'd0) begin n_fail++; $display("FAIL exc_tail got %0h exp 0", alloc_rob_index[IW-1:0]); end
        n_tests++; if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL exc_flush_pulse got %0h exp 0", flush_valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        int          retired;
        do_reset();
        exp_q.delete();
        retired = 0;
        for (int i = 0; i < 70; i++) begin
            drive_alloc(2'b01, 32'h1000 + 32'(4*i), 32'h0);
            exp_q.push_back(32'h1000 + 32'(4*i));
            n_tests++; if (alloc_rob_index[IW-1:0] !== 6'(i % 64)) begin n_fail++; $display("FAIL wrap_index_%0d got %0h exp %0h", i, alloc_rob_index[IW-1:0], i % 64); end
            tick();
            clear_inputs();
            drive_cmpl(i % NF, 6'(i % 64), 1'b0, 1'b0);
            tick();
            clear_inputs();
            exp_pc = exp_q.pop_front();
            n_tests++; if (retire_valid !== 4'b0001 || retire_pc[31:0] !== exp_pc) begin n_fail++; $display("FAIL wrap_retire_%0d got v=%0h pc=%0h exp v=1 pc=%0h", i, retire_valid, retire_pc[31:0], exp_pc); end
            if (retire_valid[0]) retired++;
            tick();
        end
        n_tests++; if (retired != 70) begin n_fail++; $display("FAIL wrap_retired_count got %0d exp 70", retired); end
        n_tests++; if (rob_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %0h exp 1", rob_empty); end
`ifdef ROB_PERF_CNT_EN
        n_tests++; if (perf_retired !== 32'd70) begin n_fail++; $display("FAIL perf_retired got %0d exp 70", perf_retired); end
        n_tests++; if (perf_flushes !== 32'd0) begin n_fail++; $display("FAIL perf_flushes got %0d exp 0", perf_flushes); end
`endif
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_fill();
        test_ooo();
        test_mispredict();
        test_exception();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
